// File: rtl/reward_pkg.sv
// Shared types and constants for the multi-slot reward sprite engine.
// Sprite indices, reward type codes, palette colours and slot states.
package reward_pkg;

    typedef enum logic [2:0] {
        SPR_PROTECT = 3'd0,
        SPR_ADDTIME = 3'd1,
        SPR_FASTER  = 3'd2,
        SPR_FROZEN  = 3'd3,
        SPR_LASER   = 3'd4
    } spr_e;

    typedef enum logic [1:0] {
        SLOT_FREE  = 2'd0,
        SLOT_LIVE  = 2'd1,
        SLOT_BLINK = 2'd2
    } slot_e;

    localparam logic [2:0] TYPE_BONUS  = 3'd1;
    localparam logic [2:0] TYPE_FASTER = 3'd2;
    localparam logic [2:0] TYPE_FROZEN = 3'd3;
    localparam logic [2:0] TYPE_LASER  = 3'd4;

    localparam logic [11:0] COL_PROTECT = 12'h0FF;
    localparam logic [11:0] COL_FASTER  = 12'h0F0;
    localparam logic [11:0] COL_FROZEN  = 12'h00F;
    localparam logic [11:0] COL_LASER   = 12'hF00;
    localparam logic [11:0] COL_BLINK   = 12'hFF0;
    localparam logic [11:0] COL_WHITE   = 12'hFFF;

    // Type 1 is mode dependent; classic takes priority when both are set.
    function automatic spr_e type_spr(input logic [2:0] t, input logic inf);
        spr_e s;
        s = SPR_PROTECT;
        case (t)
            TYPE_BONUS:  s = inf ? SPR_ADDTIME : SPR_PROTECT;
            TYPE_FASTER: s = SPR_FASTER;
            TYPE_FROZEN: s = SPR_FROZEN;
            TYPE_LASER:  s = SPR_LASER;
            default:     s = SPR_PROTECT;
        endcase
        return s;
    endfunction

    function automatic logic [11:0] spr_color(input spr_e s);
        logic [11:0] c;
        c = COL_PROTECT;
        case (s)
            SPR_FASTER: c = COL_FASTER;
            SPR_FROZEN: c = COL_FROZEN;
            SPR_LASER:  c = COL_LASER;
            default:    c = COL_PROTECT;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/reward_sprite_rom.sv
// Combined 1-bit sprite ROM for all five reward pictures.
// Address is {sprite_idx, row*SPRITE+col}; read data appears one cycle later.
module reward_sprite_rom
    import reward_pkg::*;
#(
    parameter int SPRITE = 24,
    parameter int AW     = 10
) (
    input  logic          clk,
    input  logic [AW+2:0] addr_i,
    output logic          bit_o
);

    logic bit_d;
    logic bit_q;
    int   a;
    int   r;
    int   c;

    // Procedural pictures: border, plus, stripes, checker, bars.
    always_comb begin
        a = int'(addr_i[AW-1:0]);
        r = a / SPRITE;
        c = a % SPRITE;
        bit_d = 1'b0;
        case (addr_i[AW+2:AW])
            SPR_PROTECT: bit_d = (r == 0) || (r == SPRITE-1) ||
                                 (c == 0) || (c == SPRITE-1);
            SPR_ADDTIME: bit_d = (c >= SPRITE/2-2 && c < SPRITE/2+2) ||
                                 (r >= SPRITE/2-2 && r < SPRITE/2+2);
            SPR_FASTER:  bit_d = ((r + c) % 4) < 2;
            SPR_FROZEN:  bit_d = ((r/2 + c/2) % 2) == 1;
            SPR_LASER:   bit_d = (r % 8) < 4;
            default:     bit_d = 1'b0;
        endcase
    end

    // Synchronous read register.
    always_ff @(posedge clk) begin
        bit_q <= bit_d;
    end

    assign bit_o = bit_q;

endmodule

// File: rtl/reward_sprite_engine.sv
// Multi-slot reward sprite engine: slot lifetimes plus 2-cycle VGA render.
// Optional macro REWARD_COLOR_EN enables the per-type palette and blink colour.
module reward_sprite_engine
    import reward_pkg::*;
#(
    parameter  int N_SLOTS      = 4,
    parameter  int GRID_W       = 5,
    parameter  int PITCH        = 20,
    parameter  int ORIGIN       = 80,
    parameter  int SPRITE       = 24,
    parameter  int LIFE_FRAMES  = 600,
    parameter  int BLINK_FRAMES = 120,
    parameter  int BLINK_DIV    = 8,
    localparam int SW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               enable_reward,
    input  logic               enable_game_classic,
    input  logic               enable_game_infinity,
    input  logic               spawn_valid,
    output logic               spawn_ready,
    input  logic [GRID_W-1:0]  spawn_xpos,
    input  logic [GRID_W-1:0]  spawn_ypos,
    input  logic [2:0]         spawn_type,
    input  logic               collect_valid,
    input  logic [SW-1:0]      collect_slot,
    input  logic [10:0]        VGA_xpos,
    input  logic [10:0]        VGA_ypos,
    output logic [11:0]        VGA_data,
    output logic               pixel_hit,
    output logic [N_SLOTS-1:0] slot_active,
    output logic               expired_pulse
);

    localparam int HALF = SPRITE / 2;
    localparam int AW   = $clog2(SPRITE * SPRITE);
    localparam int LW   = $clog2(LIFE_FRAMES + 1);

    typedef logic [LW-1:0] life_t;

    slot_e             state_q [N_SLOTS];
    slot_e             state_d [N_SLOTS];
    life_t             life_q  [N_SLOTS];
    life_t             life_d  [N_SLOTS];
    logic [2:0]        type_q  [N_SLOTS];
    logic [2:0]        type_d  [N_SLOTS];
    logic [GRID_W-1:0] xg_q    [N_SLOTS];
    logic [GRID_W-1:0] xg_d    [N_SLOTS];
    logic [GRID_W-1:0] yg_q    [N_SLOTS];
    logic [GRID_W-1:0] yg_d    [N_SLOTS];
    logic              expired_q, expired_d;

    logic              spawn_rdy;
    logic [SW-1:0]     spawn_sel;
    logic              spawn_ok;
    logic              age;
    logic              inf;

    logic              hit_d, hit_q;
    logic [11:0]       fg_d, fg_q;
    spr_e              idx_d;
    logic [AW-1:0]     addr_d;
    logic              rom_bit;
    logic [11:0]       vga_q;
    logic              pix_q;

    assign age = frame_tick && enable_reward;
    assign inf = enable_game_infinity && !enable_game_classic;
    assign spawn_ok = spawn_valid && spawn_rdy &&
                      (spawn_type >= TYPE_BONUS) &&
                      (spawn_type <= TYPE_LASER);

    // Lowest-index free slot; a slot freed this cycle is not yet free.
    always_comb begin
        spawn_rdy = 1'b0;
        spawn_sel = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (state_q[i] == SLOT_FREE) begin
                spawn_rdy = 1'b1;
                spawn_sel = SW'(i);
            end
        end
    end

    // Per-slot FSM next state: spawn, collect, ageing and expiry.
    always_comb begin : slot_next
        logic coll;
        coll = 1'b0;
        expired_d = 1'b0;
        for (int i = 0; i < N_SLOTS; i++) begin
            state_d[i] = state_q[i];
            life_d[i]  = life_q[i];
            type_d[i]  = type_q[i];
            xg_d[i]    = xg_q[i];
            yg_d[i]    = yg_q[i];
            coll = collect_valid && (collect_slot == SW'(i));
            case (state_q[i])
                SLOT_FREE: begin
                    if (spawn_ok && spawn_sel == SW'(i)) begin
                        life_d[i]  = life_t'(LIFE_FRAMES);
                        type_d[i]  = spawn_type;
                        xg_d[i]    = spawn_xpos;
                        yg_d[i]    = spawn_ypos;
                        state_d[i] = (LIFE_FRAMES <= BLINK_FRAMES) ?
                                     SLOT_BLINK : SLOT_LIVE;
                    end
                end
                SLOT_LIVE, SLOT_BLINK: begin
                    if (coll) begin
                        state_d[i] = SLOT_FREE;
                    end else if (age) begin
                        if (life_q[i] == life_t'(1)) begin
                            state_d[i] = SLOT_FREE;
                            expired_d  = 1'b1;
                        end else begin
                            life_d[i] = life_q[i] - life_t'(1);
                            if (life_d[i] <= life_t'(BLINK_FRAMES))
                                state_d[i] = SLOT_BLINK;
                        end
                    end
                end
                default: state_d[i] = SLOT_FREE;
            endcase
        end
    end

    // Slot state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                state_q[i] <= SLOT_FREE;
                life_q[i]  <= '0;
                type_q[i]  <= '0;
                xg_q[i]    <= '0;
                yg_q[i]    <= '0;
            end
            expired_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_SLOTS; i++) begin
                state_q[i] <= state_d[i];
                life_q[i]  <= life_d[i];
                type_q[i]  <= type_d[i];
                xg_q[i]    <= xg_d[i];
                yg_q[i]    <= yg_d[i];
            end
            expired_q <= expired_d;
        end
    end

    // Stage 0: hit test, lowest-index winner, ROM address and colour.
    always_comb begin : render_s0
        logic [11:0] xp, yp, xc, yc, xl, yl, ox, oy;
        logic        in_x, in_y, won, odd;
        xp = {1'b0, VGA_xpos};
        yp = {1'b0, VGA_ypos};
        xc = '0; yc = '0; xl = '0; yl = '0; ox = '0; oy = '0;
        in_x = 1'b0; in_y = 1'b0; won = 1'b0; odd = 1'b0;
        hit_d  = 1'b0;
        idx_d  = SPR_PROTECT;
        addr_d = '0;
        fg_d   = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            xc = 12'(xg_q[i]) * 12'(PITCH) + 12'(ORIGIN);
            yc = 12'(yg_q[i]) * 12'(PITCH) + 12'(ORIGIN);
            xl = (xc >= 12'(HALF)) ? xc - 12'(HALF) : 12'd0;
            yl = (yc >= 12'(HALF)) ? yc - 12'(HALF) : 12'd0;
            in_x = (xp > xl) && (xp <= xc + 12'(HALF));
            in_y = (yp > yl) && (yp <= yc + 12'(HALF));
            if (!won && state_q[i] != SLOT_FREE && in_x && in_y) begin
                won = 1'b1;
                odd = ((int'(life_q[i]) / BLINK_DIV) % 2) == 1;
                hit_d = enable_reward &&
                        !(state_q[i] == SLOT_BLINK && odd);
                ox = xp + 12'(HALF - 1) - xc;
                oy = yp + 12'(HALF - 1) - yc;
                addr_d = AW'(ox + oy * 12'(SPRITE));
                idx_d = type_spr(type_q[i], inf);
`ifdef REWARD_COLOR_EN
                fg_d = (state_q[i] == SLOT_BLINK) ?
                       COL_BLINK : spr_color(idx_d);
`else
                fg_d = COL_WHITE;
`endif
            end
        end
    end

    // Stage 0/1 boundary: hit and colour travel alongside the ROM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q <= 1'b0;
            fg_q  <= '0;
        end else begin
            hit_q <= hit_d;
            fg_q  <= fg_d;
        end
    end

    reward_sprite_rom #(
        .SPRITE (SPRITE),
        .AW     (AW)
    ) u_rom (
        .clk    (clk),
        .addr_i ({idx_d, addr_d}),
        .bit_o  (rom_bit)
    );

    // Stage 2: final colour register.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_q <= '0;
            pix_q <= 1'b0;
        end else begin
            pix_q <= hit_q && rom_bit;
            vga_q <= (hit_q && rom_bit) ? fg_q : 12'h000;
        end
    end

    always_comb begin
        for (int i = 0; i < N_SLOTS; i++)
            slot_active[i] = (state_q[i] != SLOT_FREE);
    end

    assign spawn_ready   = spawn_rdy;
    assign VGA_data      = vga_q;
    assign pixel_hit     = pix_q;
    assign expired_pulse = expired_q;

endmodule

// File: tb/tb_reward_sprite_engine.sv
// Directed bench for reward_sprite_engine with short lifetimes.
// Table of pixel vectors plus hand-written multi-cycle sequences.
module tb_reward_sprite_engine;

`ifdef REWARD_COLOR_EN
    localparam logic [11:0] FG_FAST  = 12'h0F0;
    localparam logic [11:0] FG_FROZ  = 12'h00F;
    localparam logic [11:0] FG_LAS   = 12'hF00;
    localparam logic [11:0] FG_PROT  = 12'h0FF;
    localparam logic [11:0] FG_ADD   = 12'h0FF;
    localparam logic [11:0] FG_BLINK = 12'hFF0;
`else
    localparam logic [11:0] FG_FAST  = 12'hFFF;
    localparam logic [11:0] FG_FROZ  = 12'hFFF;
    localparam logic [11:0] FG_LAS   = 12'hFFF;
    localparam logic [11:0] FG_PROT  = 12'hFFF;
    localparam logic [11:0] FG_ADD   = 12'hFFF;
    localparam logic [11:0] FG_BLINK = 12'hFFF;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        enable_reward = 1'b1;
    logic        classic = 1'b1;
    logic        infinity = 1'b0;
    logic        spawn_valid = 1'b0;
    logic        spawn_ready;
    logic [4:0]  spawn_xpos = '0;
    logic [4:0]  spawn_ypos = '0;
    logic [2:0]  spawn_type = '0;
    logic        collect_valid = 1'b0;
    logic [1:0]  collect_slot = '0;
    logic [10:0] vx = '0;
    logic [10:0] vy = '0;
    logic [11:0] VGA_data;
    logic        pixel_hit;
    logic [3:0]  slot_active;
    logic        expired_pulse;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          x;
        int          y;
        logic [11:0] data;
        logic        hit;
    } vec_t;

    vec_t vt [11];

    always #5 clk = ~clk;

    reward_sprite_engine #(
        .LIFE_FRAMES  (10),
        .BLINK_FRAMES (4),
        .BLINK_DIV    (1)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .frame_tick           (frame_tick),
        .enable_reward        (enable_reward),
        .enable_game_classic  (classic),
        .enable_game_infinity (infinity),
        .spawn_valid          (spawn_valid),
        .spawn_ready          (spawn_ready),
        .spawn_xpos           (spawn_xpos),
        .spawn_ypos           (spawn_ypos),
        .spawn_type           (spawn_type),
        .collect_valid        (collect_valid),
        .collect_slot         (collect_slot),
        .VGA_xpos             (vx),
        .VGA_ypos             (vy),
        .VGA_data             (VGA_data),
        .pixel_hit            (pixel_hit),
        .slot_active          (slot_active),
        .expired_pulse        (expired_pulse)
    );

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic spawn(input int x, input int y, input int t);
        spawn_xpos  = 5'(x);
        spawn_ypos  = 5'(y);
        spawn_type  = 3'(t);
        spawn_valid = 1'b1;
        step();
        spawn_valid = 1'b0;
    endtask

    task automatic collect(input int s);
        collect_slot  = 2'(s);
        collect_valid = 1'b1;
        step();
        collect_valid = 1'b0;
    endtask

    task automatic pix(input int x, input int y);
        vx = 11'(x);
        vy = 11'(y);
        step(2);
    endtask

    task automatic ftick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    initial begin
        // slot0: faster at cell (3,2): centre (140,120), first pixel (129,109)
        vt[0]  = '{129, 109, FG_FAST, 1'b1};
        vt[1]  = '{128, 109, 12'h000, 1'b0};
        vt[2]  = '{131, 109, 12'h000, 1'b0};
        vt[3]  = '{130, 109, FG_FAST, 1'b1};
        vt[4]  = '{151, 132, FG_FAST, 1'b1};
        vt[5]  = '{152, 132, 12'h000, 1'b0};
        vt[6]  = '{153, 109, 12'h000, 1'b0};
        vt[7]  = '{129, 133, 12'h000, 1'b0};
        vt[8]  = '{129, 108, 12'h000, 1'b0};
        vt[9]  = '{142, 120, FG_FAST, 1'b1};
        vt[10] = '{141, 120, 12'h000, 1'b0};

        step(2);
        rst = 1'b0;
        chk("rst_data", 32'(VGA_data), 0);
        chk("rst_hit", 32'(pixel_hit), 0);
        chk("rst_active", 32'(slot_active), 0);
        chk("rst_expired", 32'(expired_pulse), 0);
        chk("rst_ready", 32'(spawn_ready), 1);

        spawn(3, 2, 2);
        chk("spawn0_active", 32'(slot_active), 32'h1);
        for (int i = 0; i < 11; i++) begin
            pix(vt[i].x, vt[i].y);
            chk($sformatf("vec%0d_data", i), 32'(VGA_data),
                32'(vt[i].data));
            chk($sformatf("vec%0d_hit", i), 32'(pixel_hit),
                32'(vt[i].hit));
        end

        // Fill all slots, hold a fifth request until slot 2 frees.
        spawn(10, 10, 2);
        spawn(12, 10, 2);
        spawn(14, 10, 2);
        chk("full_active", 32'(slot_active), 32'hF);
        chk("full_ready", 32'(spawn_ready), 0);
        spawn_xpos  = 5'd20;
        spawn_ypos  = 5'd20;
        spawn_type  = 3'd3;
        spawn_valid = 1'b1;
        step();
        chk("held_active", 32'(slot_active), 32'hF);
        collect_slot  = 2'd2;
        collect_valid = 1'b1;
        step();
        collect_valid = 1'b0;
        chk("freed2_active", 32'(slot_active), 32'hB);
        chk("freed2_ready", 32'(spawn_ready), 1);
        step();
        spawn_valid = 1'b0;
        chk("land2_active", 32'(slot_active), 32'hF);
        pix(471, 469);
        chk("land2_frozen", 32'(VGA_data), 32'(FG_FROZ));
        for (int s = 0; s < 4; s++) collect(s);
        chk("all_free", 32'(slot_active), 0);
        spawn(3, 2, 0);
        spawn(3, 2, 5);
        chk("bad_type_drop", 32'(slot_active), 0);

        // Overlap: laser in slot0 beats frozen in slot1.
        spawn(3, 2, 4);
        spawn(3, 2, 3);
        chk("ovl_active", 32'(slot_active), 32'h3);
        pix(129, 109);
        chk("ovl_laser_on", 32'(VGA_data), 32'(FG_LAS));
        pix(131, 113);
        chk("ovl_laser_off", 32'(VGA_data), 0);
        collect(0);
        collect(1);

        // Type 1: protect in classic, addtime in infinity.
        spawn(3, 2, 1);
        pix(129, 109);
        chk("classic_a0", 32'(VGA_data), 32'(FG_PROT));
        pix(140, 120);
        chk("classic_mid", 32'(VGA_data), 0);
        classic  = 1'b0;
        infinity = 1'b1;
        pix(129, 109);
        chk("inf_a0", 32'(VGA_data), 0);
        pix(140, 120);
        chk("inf_mid", 32'(VGA_data), 32'(FG_ADD));
        classic  = 1'b1;
        infinity = 1'b0;
        collect(0);

        // Lifetime: disabled ticks hold, then blink and expiry.
        spawn(3, 2, 2);
        enable_reward = 1'b0;
        ftick();
        ftick();
        ftick();
        pix(129, 109);
        chk("disabled_data", 32'(VGA_data), 0);
        enable_reward = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            logic [11:0] e;
            ftick();
            chk($sformatf("tick%0d_exp", k), 32'(expired_pulse),
                32'(k == 10));
            if (k == 10) chk("tick10_active", 32'(slot_active), 0);
            step(2);
            if (k <= 5)      e = FG_FAST;
            else if (k == 6) e = FG_BLINK;
            else if (k == 8) e = FG_BLINK;
            else             e = 12'h000;
            chk($sformatf("tick%0d_data", k), 32'(VGA_data), 32'(e));
        end
        chk("exp_pulse_end", 32'(expired_pulse), 0);

        // Collect and expiry on the same slot and cycle.
        spawn(3, 2, 2);
        for (int k = 0; k < 9; k++) ftick();
        chk("pre_collide_active", 32'(slot_active), 32'h1);
        frame_tick    = 1'b1;
        collect_slot  = 2'd0;
        collect_valid = 1'b1;
        step();
        frame_tick    = 1'b0;
        collect_valid = 1'b0;
        chk("collide_exp", 32'(expired_pulse), 0);
        chk("collide_active", 32'(slot_active), 0);

        // Reset during an active line.
        spawn(3, 2, 2);
        pix(129, 109);
        chk("prerst_data", 32'(VGA_data), 32'(FG_FAST));
        rst = 1'b1;
        step();
        chk("midrst_data", 32'(VGA_data), 0);
        chk("midrst_active", 32'(slot_active), 0);
        rst = 1'b0;
        step(2);
        chk("postrst_data", 32'(VGA_data), 0);
        chk("postrst_hit", 32'(pixel_hit), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reward_sprite_engine.md
Name: reward_sprite_engine

Overview:
Multi-slot successor to the single-reward overlay. Holds up to N_SLOTS live rewards on the play grid, each with its own type, grid position and lifetime. Renders them into the VGA pixel stream through a fixed-latency pipeline that is aligned to the pixel coordinates. Sits between the reward generator (spawn side), the collision/pickup logic (collect side) and the VGA colour mux.

Parameters:
N_SLOTS, 4, number of concurrent reward slots (1..8)
GRID_W, 5, width of grid x/y coordinate
PITCH, 20, grid pitch in pixels
ORIGIN, 80, pixel offset of grid cell 0 centre
SPRITE, 24, sprite edge in pixels (even); HALF = SPRITE/2
LIFE_FRAMES, 600, frames a reward lives before expiry
BLINK_FRAMES, 120, final frames during which the sprite blinks
BLINK_DIV, 8, frames per blink half-period

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-high reset
frame_tick  in  1  one-cycle pulse per frame (start of vblank)
enable_reward  in  1  global render and age enable
enable_game_classic  in  1  classic mode select
enable_game_infinity  in  1  infinity mode select
spawn_valid  in  1  spawn request
spawn_ready  out  1  free slot available
spawn_xpos  in  GRID_W  grid x
spawn_ypos  in  GRID_W  grid y
spawn_type  in  3  reward type (1..4)
collect_valid  in  1  pickup strobe
collect_slot  in  $clog2(N_SLOTS)  slot picked up
VGA_xpos  in  11  current pixel x
VGA_ypos  in  11  current pixel y
VGA_data  out  12  pixel colour, valid 2 cycles after coordinates
pixel_hit  out  1  sprite foreground at the VGA_data pixel
slot_active  out  N_SLOTS  per-slot occupancy
expired_pulse  out  1  one-cycle pulse when any slot times out

Behaviour:
- Reset: all slots free; VGA_data=0, pixel_hit=0, slot_active=0, expired_pulse=0, pipeline flushed. A reset mid-frame leaves outputs at 0 until new coordinates have propagated through the pipeline.
- Spawn: spawn_ready = any slot free. The transfer happens when spawn_valid && spawn_ready. It takes the lowest-index free slot and loads life=LIFE_FRAMES. slot_active is set the next cycle. spawn_type 0 or >4 is accepted but dropped, and no slot is consumed.
- Collect: collect_valid on an active slot frees it the next cycle. Collecting an inactive slot is ignored. If a collect and a spawn occur in the same cycle, the spawn cannot use the slot being freed that cycle.
- Ageing: on frame_tick && enable_reward, each active slot decrements life. When life reaches 1 and ticks, the slot frees and expired_pulse=1 for one cycle. If a collect and an expiry hit the same slot in the same cycle, the slot frees and expired_pulse=0.
- Slot FSM per slot: FREE -> LIVE (spawn) -> BLINK (life<=BLINK_FRAMES) -> FREE (expiry or collect). LIVE also goes -> FREE on collect.
- Blink: in BLINK, the sprite is hidden when (life/BLINK_DIV) is odd.
- Geometry: centre xc = pos*PITCH+ORIGIN. A pixel is a hit if xc-HALF < x <= xc+HALF, and likewise for y. Sprite address = (x-xc+HALF-1) + SPRITE*(y-yc+HALF-1), range 0..SPRITE*SPRITE-1. Arithmetic is 12-bit unsigned; a negative left bound clamps to 0.
- Sprite select: type 1 uses protect in classic mode and addtime in infinity mode; 2 = faster, 3 = frozen, 4 = laser.
- Overlap: the lowest-index hit slot wins.
- Pipeline:
  - Stage 0: hit test, winner select, address and sprite index registered.
  - Stage 1: ROM read (1-cycle synchronous).
  - Stage 2: colour registered.
  - Total latency is exactly 2 cycles from VGA_xpos/VGA_ypos to VGA_data.
- Background: VGA_data=0 when there is no hit, the ROM bit is 0, or enable_reward=0.
- With enable_reward=0, slots hold their lifetimes, spawns are still accepted, and collects still apply.

Optional Feature:
- Macro: REWARD_COLOR_EN.
- Defined: foreground colour comes from a per-type palette: protect/addtime 12'h0FF, faster 12'h0F0, frozen 12'h00F, laser 12'hF00. During BLINK, the visible half-period uses 12'hFF0.
- Undefined: foreground is always 12'hFFF, and the blink hides the sprite only.

Decomposition:
- Package reward_pkg holds:
  - sprite index enum (SPR_PROTECT, SPR_ADDTIME, SPR_FASTER, SPR_FROZEN, SPR_LASER);
  - reward type constants 1..4;
  - the palette constants;
  - the slot state enum.
- Sub-module reward_sprite_rom: a single synchronous ROM addressed by {sprite_idx, addr} with a 1-bit output and 1-cycle latency. It replaces the five separate pictures.

Test Plan:
- Reset then spawn (x=3,y=2,type=2): slot0 active. Pixel (129,109) → 2 cycles later VGA_data=12'hFFF when the faster-ROM bit at addr 0 is 1; pixel (128,109) → 0.
- Spawn N_SLOTS+1 times: spawn_ready drops after the 4th spawn. The 5th request is held until collect_slot=2, then lands in slot 2.
- Two rewards overlap at the same cell with type 3 in slot1 and type 4 in slot0: the laser sprite is shown.
- LIFE_FRAMES=10, BLINK_FRAMES=4, BLINK_DIV=1, 10 frame_ticks: blinking on ticks 6-9; on tick 10, expired_pulse=1 and slot_active[0]=0.
- Type 1 with classic=1 then infinity=1: the ROM output switches between protect and addtime at the same address.
- Assert rst during an active line: VGA_data=0 the next cycle, and all slots are free.
